// File: rtl/store_memory_rmw.sv
// Store path into a word-wide RAM without byte enables: SW writes directly, SB/SH read-modify-write.
// Latency: SW write at T+1, SB/SH write at T+3; req_ready low while busy. Optional trap: STORE_MISALIGN_TRAP_EN.
module store_memory_rmw #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_type,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  done,
  output logic                  misalign
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  localparam logic [2:0] TYPE_SB = 3'b000;
  localparam logic [2:0] TYPE_SH = 3'b001;

  state_t                  r_state;
  logic [1:0]              r_addr_lo;
  logic [2:0]              r_type;
  logic [15:0]             r_wdata_lo;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic                    r_mem_re;
  logic                    r_mem_we;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic                    r_done;

  logic                    w_accept;
  logic                    w_rmw;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_rmw     = (req_type == TYPE_SB) || (req_type == TYPE_SH);

`ifdef STORE_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misaligned;
  assign w_misaligned = ((req_type == TYPE_SH) && req_addr[0]) ||
                        (!w_rmw && (req_addr[1:0] != 2'b00));
  assign misalign     = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  // Only the addressed lane(s) change; the rest of the word is the value just read.
  always_comb begin
    w_merged = mem_rdata;
    if (r_type == TYPE_SB) begin
      w_merged[{r_addr_lo, 3'b000} +: 8] = r_wdata_lo[7:0];
    end else if (r_addr_lo[1]) begin
      w_merged[31:16] = r_wdata_lo;
    end else begin
      w_merged[15:0] = r_wdata_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr_lo   <= '0;
      r_type      <= '0;
      r_wdata_lo  <= '0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_done     <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr_lo  <= req_addr[1:0];
            r_type     <= req_type;
            r_wdata_lo <= req_wdata[15:0];
`ifdef STORE_MISALIGN_TRAP_EN
            // Trapped requests pass through WRITE without touching memory.
            if (w_misaligned) begin
              r_state    <= WRITE;
              r_misalign <= 1'b1;
            end else
`endif
            if (w_rmw) begin
              r_state    <= READ;
              r_mem_re   <= 1'b1;
              r_mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            end else begin
              r_state     <= WRITE;
              r_mem_we    <= 1'b1;
              r_done      <= 1'b1;
              r_mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              r_mem_wdata <= req_wdata;
            end
          end
        end
        READ: begin
          r_state <= WAIT;
        end
        WAIT: begin
          r_state     <= WRITE;
          r_mem_wdata <= w_merged;
          r_mem_we    <= 1'b1;
          r_done      <= 1'b1;
        end
        WRITE: begin
          r_state    <= IDLE;
          r_mem_addr <= '0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;

endmodule

// File: tb/tb_store_memory_rmw.sv
// Bench for store_memory_rmw: directed cases plus random stores checked against a lane-level word model.
module tb_store_memory_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        done;
  logic        misalign;

  int checks = 0;
  int failures = 0;
  int we_count = 0;

  logic [31:0] ram   [256];
  logic [31:0] model [256];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_val;

  always #5 clk = ~clk;

  store_memory_rmw #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .done(done), .misalign(misalign)
  );

  // Synchronous RAM: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[9:2]] <= mem_wdata;
      we_count <= we_count + 1;
    end
    if (ld_en) ram[ld_idx] <= ld_val;
    if (mem_re) mem_rdata <= ram[mem_addr[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [2:0] t, input logic [31:0] d);
    logic [7:0] b [4];
    int h;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    if (t == 3'd0) begin
      b[a % 4] = d[7:0];
    end else if (t == 3'd1) begin
      h = (a / 2) % 2;
      b[2*h]     = d[7:0];
      b[2*h + 1] = d[15:8];
    end else begin
      return d;
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = a[9:2]; ld_val = v;
    model[a[9:2]] = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d);
    logic rmw, mis;
    int lat;
    logic [31:0] nw;
    logic [4:0] e;
    rmw = (t == 3'd0) || (t == 3'd1);
    mis = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    mis = ((t == 3'd1) && a[0]) || (!rmw && (a[1:0] != 2'b00));
`endif
    lat = (rmw && !mis) ? 3 : 1;
    nw  = mis ? model[a[9:2]] : apply_store(model[a[9:2]], a, t, d);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_type = t; req_wdata = d;
    check("ready_before_accept", {31'd0, req_ready}, 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      // Junk requests while busy must be ignored.
      req_addr = {22'd0, 10'($urandom)}; req_type = 3'($urandom); req_wdata = $urandom;
      e = {1'b0, (k == 1) && rmw && !mis, (k == lat) && !mis, (k == lat) && !mis, (k == 1) && mis};
      check("ctl{rdy,re,we,done,mis}", {27'd0, req_ready, mem_re, mem_we, done, misalign}, {27'd0, e});
      if (!mis) check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      if (!mis && k == lat) check("mem_wdata", mem_wdata, nw);
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("idle_after{rdy,re,we}", {29'd0, req_ready, mem_re, mem_we}, 32'b100);
    check("idle_addr", mem_addr, 32'd0);
    model[a[9:2]] = nw;
  endtask

  initial begin
    int bad;
    int wc0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_type = '0; req_wdata = '0;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);
    check("rst_ctl{rdy,re,we,done,mis}", {27'd0, req_ready, mem_re, mem_we, done, misalign}, 32'b10000);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    set_word(32'h100, 32'hAABBCCDD);
    do_store(32'h101, 3'd0, 32'h12345677);
    check("plan_sb", ram[8'h40], 32'hAABB77DD);
    set_word(32'h100, 32'hAABBCCDD);
    do_store(32'h102, 3'd1, 32'h0000BEEF);
    check("plan_sh_hi", ram[8'h40], 32'hBEEFCCDD);
    set_word(32'h100, 32'hAABBCCDD);
    do_store(32'h100, 3'd1, 32'h0000BEEF);
    check("plan_sh_lo", ram[8'h40], 32'hAABBBEEF);
    do_store(32'h104, 3'd2, 32'hCAFEF00D);
    check("plan_sw", ram[8'h41], 32'hCAFEF00D);
    do_store(32'h108, 3'd5, 32'h5A5A1234);
    check("plan_type5_as_sw", ram[8'h42], 32'h5A5A1234);

    // Back-to-back with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h200; req_type = 3'd2; req_wdata = 32'h11223344;
    check("b2b_ready_T", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_addr = 32'h203; req_type = 3'd0; req_wdata = 32'h000000FF;
    check("b2b_ctl_T1", {29'd0, req_ready, mem_we, done}, 32'b011);
    check("b2b_wdata_T1", mem_wdata, 32'h11223344);
    check("b2b_addr_T1", mem_addr, 32'h200);
    @(negedge clk);
    check("b2b_ready_T2", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_ctl_T3{rdy,re,we}", {29'd0, req_ready, mem_re, mem_we}, 32'b010);
    @(negedge clk);
    check("b2b_ctl_T4{re,we}", {30'd0, mem_re, mem_we}, 32'b00);
    @(negedge clk);
    check("b2b_ctl_T5{we,done}", {30'd0, mem_we, done}, 32'b11);
    check("b2b_wdata_T5", mem_wdata, 32'hFF223344);
    @(negedge clk);
    check("b2b_ready_T6", {31'd0, req_ready}, 32'd1);
    check("b2b_ram", ram[8'h80], 32'hFF223344);
    model[8'h80] = 32'hFF223344;

    // Reset during WAIT: no write may escape.
    set_word(32'h300, 32'h01020304);
    wc0 = we_count;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h301; req_type = 3'd0; req_wdata = 32'h000000AB;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_re", {31'd0, mem_re}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_ctl{rdy,re,we,done}", {28'd0, req_ready, mem_re, mem_we, done}, 32'b1000);
    check("rstmid_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_no_write", 32'(we_count - wc0), 32'd0);
    check("rstmid_ram", ram[8'hC0], 32'h01020304);
    do_store(32'h300, 3'd2, 32'h76543210);

    set_word(32'h100, 32'hAABBCCDD);
    do_store(32'h103, 3'd1, 32'h0000BEEF);
`ifdef STORE_MISALIGN_TRAP_EN
    check("plan_sh_odd", ram[8'h40], 32'hAABBCCDD);
`else
    check("plan_sh_odd", ram[8'h40], 32'hBEEFCCDD);
`endif

    for (int n = 0; n < 60; n++)
      do_store({22'd0, 10'($urandom)}, 3'($urandom), $urandom);

    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== model[i]) bad++;
    check("final_ram_vs_model", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
